// File: rtl/mesh_xy_router.sv
// mesh_xy_router: one node of a 2-D mesh NoC.
// Five buffered inputs, XY routing, per-output round-robin arbitration.
module mesh_xy_router #(
    parameter int ROW_N        = 3,
    parameter int COL_M        = 3,
    parameter int X_COORD      = 0,
    parameter int Y_COORD      = 0,
    parameter int FIFO_DEPTH_W = 3,
    parameter int PCKT_DATA_W  = 8,
    localparam int CW          = $clog2(COL_M),
    localparam int RW          = $clog2(ROW_N),
    localparam int PACKET_W    = PCKT_DATA_W + RW + CW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [5*PACKET_W-1:0] pckt_i,
    input  logic [4:0]            wren_i,
    output logic [4:0]            full_o,
    output logic [4:0]            ovrflw_o,
    output logic [5*PACKET_W-1:0] pckt_o,
    output logic [4:0]            wren_o,
    input  logic [4:0]            full_i
);

    localparam int DEPTH = 1 << FIFO_DEPTH_W;
    localparam logic [FIFO_DEPTH_W:0] CNT_FULL = (FIFO_DEPTH_W+1)'(DEPTH);
    localparam logic [CW-1:0] XC = CW'(X_COORD);
    localparam logic [RW-1:0] YC = RW'(Y_COORD);

    logic [PACKET_W-1:0]     mem_q    [5][DEPTH];
    logic [PACKET_W-1:0]     mem_d    [5][DEPTH];
    logic [FIFO_DEPTH_W-1:0] wr_ptr_q [5];
    logic [FIFO_DEPTH_W-1:0] wr_ptr_d [5];
    logic [FIFO_DEPTH_W-1:0] rd_ptr_q [5];
    logic [FIFO_DEPTH_W-1:0] rd_ptr_d [5];
    logic [FIFO_DEPTH_W:0]   cnt_q    [5];
    logic [FIFO_DEPTH_W:0]   cnt_d    [5];
    logic [2:0]              rr_q     [5];
    logic [2:0]              rr_d     [5];
    logic [4:0]              ovrflw_q;
    logic [4:0]              ovrflw_d;

    logic [PACKET_W-1:0]     head     [5];
    logic [4:0]              req      [5];
    logic [4:0]              gnt_vld;
    logic [2:0]              gnt_idx  [5];
    logic [4:0]              pop;

    // Full flags come straight from the pre-edge occupancy.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            full_o[p] = (cnt_q[p] == CNT_FULL);
        end
        ovrflw_o = ovrflw_q;
    end

    // XY route of each non-empty FIFO head: X first, then Y, else local.
    always_comb begin : route
        logic [CW-1:0] dcol;
        logic [RW-1:0] drow;
        for (int p = 0; p < 5; p++) begin
            head[p] = mem_q[p][rd_ptr_q[p]];
            dcol    = head[p][CW-1:0];
            drow    = head[p][CW+RW-1:CW];
            req[p]  = '0;
            if (cnt_q[p] != '0) begin
                if (dcol > XC)      req[p][1] = 1'b1;
                else if (dcol < XC) req[p][3] = 1'b1;
                else if (drow > YC) req[p][2] = 1'b1;
                else if (drow < YC) req[p][0] = 1'b1;
                else                req[p][4] = 1'b1;
            end
        end
    end

    // Round-robin pick per output, starting at rr_q, gated by full_i.
    always_comb begin : arb
        int   idx;
        logic found;
        gnt_vld = '0;
        pop     = '0;
        for (int o = 0; o < 5; o++) begin
            gnt_idx[o] = 3'd0;
            found      = 1'b0;
            for (int k = 0; k < 5; k++) begin
                idx = int'(rr_q[o]) + k;
                if (idx >= 5) idx = idx - 5;
                if (!found && req[idx][o] && !full_i[o]) begin
                    found      = 1'b1;
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = 3'(idx);
                    pop[idx]   = 1'b1;
                end
            end
        end
    end

    // Drive granted head packets onto outputs; idle outputs read zero.
    always_comb begin
        pckt_o = '0;
        wren_o = gnt_vld;
        for (int o = 0; o < 5; o++) begin
            if (gnt_vld[o]) begin
                pckt_o[o*PACKET_W +: PACKET_W] = head[gnt_idx[o]];
            end
        end
    end

    // Next-state for FIFOs, overflow pulses and arbiter pointers.
    always_comb begin : nxt
        logic push;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        ovrflw_d = '0;
        for (int p = 0; p < 5; p++) begin
            push        = wren_i[p] && !full_o[p];
            ovrflw_d[p] = wren_i[p] && full_o[p];
            if (push) begin
                mem_d[p][wr_ptr_q[p]] = pckt_i[p*PACKET_W +: PACKET_W];
                wr_ptr_d[p]           = wr_ptr_q[p] + 1'b1;
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
            end
            case ({push, pop[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + 1'b1;
                2'b01:   cnt_d[p] = cnt_q[p] - 1'b1;
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
        for (int o = 0; o < 5; o++) begin
            if (gnt_vld[o]) begin
                rr_d[o] = (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
            end
        end
    end

    // State registers; reset empties every FIFO and rewinds arbiters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '{default: '0}};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q    <= '{default: '0};
            rr_q     <= '{default: '0};
            ovrflw_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            ovrflw_q <= ovrflw_d;
        end
    end

endmodule
